// File: rtl/ascon_arbiter.sv
// Round-robin arbiter sharing one Ascon AEAD core between two block-stream requesters.
// A grant spans a whole message and ends once both the input last and output last beats complete.
module ascon_arbiter #(
  parameter int BLOCK_LENGTH = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    r0_mode,
  input  logic [BLOCK_LENGTH-1:0] r0_block_in,
  input  logic                    r0_block_in_valid,
  input  logic                    r0_block_in_last,
  output logic                    r0_block_in_ready,
  output logic [BLOCK_LENGTH-1:0] r0_block_out,
  output logic                    r0_block_out_valid,
  output logic                    r0_block_out_last,
  input  logic                    r0_block_out_ready,

  input  logic                    r1_mode,
  input  logic [BLOCK_LENGTH-1:0] r1_block_in,
  input  logic                    r1_block_in_valid,
  input  logic                    r1_block_in_last,
  output logic                    r1_block_in_ready,
  output logic [BLOCK_LENGTH-1:0] r1_block_out,
  output logic                    r1_block_out_valid,
  output logic                    r1_block_out_last,
  input  logic                    r1_block_out_ready,

  output logic                    core_mode,
  output logic [BLOCK_LENGTH-1:0] core_block_in,
  output logic                    core_block_in_valid,
  output logic                    core_block_in_last,
  input  logic                    core_block_in_ready,
  input  logic [BLOCK_LENGTH-1:0] core_block_out,
  input  logic                    core_block_out_valid,
  input  logic                    core_block_out_last,
  output logic                    core_block_out_ready,

  output logic                    busy,
  output logic                    grant,
  output logic [COUNT_WIDTH-1:0]  r0_count,
  output logic [COUNT_WIDTH-1:0]  r1_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state;
  logic   last_grant;
  logic   mode_q;
  logic   in_done;
  logic   out_done;

  logic   in_fire;
  logic   out_fire;
  logic   release_now;
  logic   winner;
  logic   any_req;

  assign busy = (state == ACTIVE);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    core_mode            = 1'b0;
    core_block_in        = '0;
    core_block_in_valid  = 1'b0;
    core_block_in_last   = 1'b0;
    core_block_out_ready = 1'b0;
    r0_block_in_ready    = 1'b0;
    r0_block_out         = '0;
    r0_block_out_valid   = 1'b0;
    r0_block_out_last    = 1'b0;
    r1_block_in_ready    = 1'b0;
    r1_block_out         = '0;
    r1_block_out_valid   = 1'b0;
    r1_block_out_last    = 1'b0;
    if (state == ACTIVE) begin
      core_mode = mode_q;
      if (grant == 1'b0) begin
        core_block_in        = r0_block_in;
        core_block_in_valid  = r0_block_in_valid;
        core_block_in_last   = r0_block_in_last;
        r0_block_in_ready    = core_block_in_ready;
        r0_block_out         = core_block_out;
        r0_block_out_valid   = core_block_out_valid;
        r0_block_out_last    = core_block_out_last;
        core_block_out_ready = r0_block_out_ready;
      end else begin
        core_block_in        = r1_block_in;
        core_block_in_valid  = r1_block_in_valid;
        core_block_in_last   = r1_block_in_last;
        r1_block_in_ready    = core_block_in_ready;
        r1_block_out         = core_block_out;
        r1_block_out_valid   = core_block_out_valid;
        r1_block_out_last    = core_block_out_last;
        core_block_out_ready = r1_block_out_ready;
      end
    end
  end

  // Handshakes are seen on the core side, so they are already gated to the granted requester.
  assign in_fire     = core_block_in_valid & core_block_in_ready & core_block_in_last;
  assign out_fire    = core_block_out_valid & core_block_out_ready & core_block_out_last;
  assign release_now = (in_done | in_fire) & (out_done | out_fire);

  assign any_req = r0_block_in_valid | r1_block_in_valid;
  assign winner  = (r0_block_in_valid & r1_block_in_valid) ? ~last_grant : r1_block_in_valid;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mode_q     <= 1'b0;
      in_done    <= 1'b0;
      out_done   <= 1'b0;
      r0_count   <= '0;
      r1_count   <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        state    <= ACTIVE;
        grant    <= winner;
        mode_q   <= winner ? r1_mode : r0_mode;
        in_done  <= 1'b0;
        out_done <= 1'b0;
      end
    end else begin
      if (in_fire)  in_done  <= 1'b1;
      if (out_fire) out_done <= 1'b1;
      if (release_now) begin
        state      <= IDLE;
        last_grant <= grant;
        if (grant == 1'b0) begin
          if (r0_count != '1) r0_count <= r0_count + COUNT_WIDTH'(1);
        end else begin
          if (r1_count != '1) r1_count <= r1_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_arbiter.sv
// Randomized bench for ascon_arbiter: the bench plays both requesters and the core, and
// predicts every output from a message-level ownership model; a 2-bit-counter copy checks saturation.
module tb_ascon_arbiter;

  localparam int BL = 64;
  localparam int CW = 16;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Requester-side stimulus, indexed by requester
  logic [1:0]    req_mode, req_valid, req_last, req_oready;
  logic [BL-1:0] req_data [2];

  // Core-side stimulus
  logic          core_block_in_ready;
  logic [BL-1:0] core_block_out;
  logic          core_block_out_valid, core_block_out_last;

  // Main DUT outputs
  logic [1:0]    in_ready, out_valid, out_last;
  logic [BL-1:0] out_data [2];
  logic          core_mode, core_block_in_valid, core_block_in_last, core_block_out_ready;
  logic [BL-1:0] core_block_in;
  logic          busy, grant;
  logic [CW-1:0] r0_count, r1_count;

  // Small-counter DUT outputs
  logic [1:0]    s_in_ready, s_out_valid, s_out_last;
  logic [BL-1:0] s_out_data [2];
  logic          s_core_mode, s_core_in_valid, s_core_in_last, s_core_out_ready;
  logic [BL-1:0] s_core_in;
  logic          s_busy, s_grant;
  logic [1:0]    s_r0_count, s_r1_count;

  ascon_arbiter #(.BLOCK_LENGTH(BL), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .r0_mode(req_mode[0]), .r0_block_in(req_data[0]), .r0_block_in_valid(req_valid[0]),
    .r0_block_in_last(req_last[0]), .r0_block_in_ready(in_ready[0]), .r0_block_out(out_data[0]),
    .r0_block_out_valid(out_valid[0]), .r0_block_out_last(out_last[0]), .r0_block_out_ready(req_oready[0]),
    .r1_mode(req_mode[1]), .r1_block_in(req_data[1]), .r1_block_in_valid(req_valid[1]),
    .r1_block_in_last(req_last[1]), .r1_block_in_ready(in_ready[1]), .r1_block_out(out_data[1]),
    .r1_block_out_valid(out_valid[1]), .r1_block_out_last(out_last[1]), .r1_block_out_ready(req_oready[1]),
    .core_mode(core_mode), .core_block_in(core_block_in), .core_block_in_valid(core_block_in_valid),
    .core_block_in_last(core_block_in_last), .core_block_in_ready(core_block_in_ready),
    .core_block_out(core_block_out), .core_block_out_valid(core_block_out_valid),
    .core_block_out_last(core_block_out_last), .core_block_out_ready(core_block_out_ready),
    .busy(busy), .grant(grant), .r0_count(r0_count), .r1_count(r1_count)
  );

  ascon_arbiter #(.BLOCK_LENGTH(BL), .COUNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst),
    .r0_mode(req_mode[0]), .r0_block_in(req_data[0]), .r0_block_in_valid(req_valid[0]),
    .r0_block_in_last(req_last[0]), .r0_block_in_ready(s_in_ready[0]), .r0_block_out(s_out_data[0]),
    .r0_block_out_valid(s_out_valid[0]), .r0_block_out_last(s_out_last[0]), .r0_block_out_ready(req_oready[0]),
    .r1_mode(req_mode[1]), .r1_block_in(req_data[1]), .r1_block_in_valid(req_valid[1]),
    .r1_block_in_last(req_last[1]), .r1_block_in_ready(s_in_ready[1]), .r1_block_out(s_out_data[1]),
    .r1_block_out_valid(s_out_valid[1]), .r1_block_out_last(s_out_last[1]), .r1_block_out_ready(req_oready[1]),
    .core_mode(s_core_mode), .core_block_in(s_core_in), .core_block_in_valid(s_core_in_valid),
    .core_block_in_last(s_core_in_last), .core_block_in_ready(core_block_in_ready),
    .core_block_out(core_block_out), .core_block_out_valid(core_block_out_valid),
    .core_block_out_last(core_block_out_last), .core_block_out_ready(s_core_out_ready),
    .busy(s_busy), .grant(s_grant), .r0_count(s_r0_count), .r1_count(s_r1_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: who owns the core (-1 = nobody), who owned it last, and message tallies.
  int owner;
  int prev_owner;
  bit held_mode;
  bit input_finished, output_finished;
  int msgs [2];

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_edge();
    int  w;
    bit  in_end, out_end;
    if (rst) begin
      owner = -1; prev_owner = 1; held_mode = 1'b0;
      input_finished = 1'b0; output_finished = 1'b0;
      msgs[0] = 0; msgs[1] = 0;
    end else if (owner < 0) begin
      if (req_valid[0] || req_valid[1]) begin
        if (req_valid[0] && req_valid[1]) w = 1 - prev_owner;
        else                              w = req_valid[1] ? 1 : 0;
        owner = w;
        held_mode = req_mode[w];
        input_finished = 1'b0;
        output_finished = 1'b0;
      end
    end else begin
      in_end  = req_valid[owner] && core_block_in_ready && req_last[owner];
      out_end = core_block_out_valid && req_oready[owner] && core_block_out_last;
      input_finished  = input_finished  || in_end;
      output_finished = output_finished || out_end;
      if (input_finished && output_finished) begin
        msgs[owner]++;
        prev_owner = owner;
        owner = -1;
      end
    end
  endtask

  task automatic check_outputs();
    bit act;
    bit mine;
    act = (owner >= 0);
    for (int r = 0; r < 2; r++) begin
      mine = (owner == r);
      check($sformatf("r%0d_in_ready", r),  64'(in_ready[r]),  64'(mine ? core_block_in_ready : 1'b0));
      check($sformatf("r%0d_out_valid", r), 64'(out_valid[r]), 64'(mine ? core_block_out_valid : 1'b0));
      check($sformatf("r%0d_out_last", r),  64'(out_last[r]),  64'(mine ? core_block_out_last : 1'b0));
      check($sformatf("r%0d_out_data", r),  out_data[r],       mine ? core_block_out : 64'd0);
    end
    check("core_mode",      64'(core_mode),            64'(act ? held_mode : 1'b0));
    check("core_in",        core_block_in,             act ? req_data[owner] : 64'd0);
    check("core_in_valid",  64'(core_block_in_valid),  64'(act ? req_valid[owner] : 1'b0));
    check("core_in_last",   64'(core_block_in_last),   64'(act ? req_last[owner] : 1'b0));
    check("core_out_ready", 64'(core_block_out_ready), 64'(act ? req_oready[owner] : 1'b0));
    check("busy",           64'(busy),                 64'(act));
    if (act) check("grant", 64'(grant), 64'(owner));
    check("r0_count",       64'(r0_count),   64'(sat(msgs[0], 65535)));
    check("r1_count",       64'(r1_count),   64'(sat(msgs[1], 65535)));
    check("small_busy",     64'(s_busy),     64'(act));
    check("small_r0_count", 64'(s_r0_count), 64'(sat(msgs[0], 3)));
    check("small_r1_count", 64'(s_r1_count), 64'(sat(msgs[1], 3)));
  endtask

  task automatic drive_idle();
    req_mode = '0; req_valid = '0; req_last = '0; req_oready = '0;
    req_data[0] = '0; req_data[1] = '0;
    core_block_in_ready = 1'b0; core_block_out = '0;
    core_block_out_valid = 1'b0; core_block_out_last = 1'b0;
  endtask

  task automatic drive_random();
    rst = (($urandom % 400) == 0);
    for (int r = 0; r < 2; r++) begin
      req_mode[r]   = 1'($urandom % 2);
      req_valid[r]  = (($urandom % 10) < 7);
      req_last[r]   = (($urandom % 4) == 0);
      req_oready[r] = (($urandom % 10) < 6);
      req_data[r]   = {$urandom, $urandom};
    end
    core_block_in_ready  = (($urandom % 10) < 7);
    core_block_out_valid = (($urandom % 10) < 6);
    core_block_out_last  = (($urandom % 4) == 0);
    core_block_out       = {$urandom, $urandom};
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs();
    @(posedge clk);
    model_edge();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      drive_random();
      #1 check_outputs();
      @(posedge clk);
      model_edge();
    end

    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1 check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
